// File: rtl/pipe_stage_ctl_reg.sv
// ID->EX control pipeline register with stall hold, flush bubble and load-use bubble insertion.
// Optional saturating stall/bubble counters are built when PIPE_STAGE_PERF_CNT_EN is defined.
module pipe_stage_ctl_reg #(
  parameter int CTL_W = 5,
  parameter int OP_W = 4,
  parameter int RA_W = 3,
  parameter int MEMREAD_BIT = 4,
  parameter logic [OP_W-1:0] NOP_OP = 4'b0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [CTL_W-1:0] ctl_i,
  input  logic [OP_W-1:0]  opcode_i,
  input  logic [RA_W-1:0]  ra_i,
  input  logic [RA_W-1:0]  rb_i,
  input  logic             use_ra_i,
  input  logic             use_rb_i,
  output logic             valid_o,
  output logic [CTL_W-1:0] ctl_o,
  output logic [OP_W-1:0]  opcode_o,
  output logic [RA_W-1:0]  ra_o,
  output logic [RA_W-1:0]  rb_o,
  output logic             hazard_o,
  output logic [15:0]      stall_cnt_o,
  output logic [15:0]      bubble_cnt_o
);

  logic             valid_r;
  logic [CTL_W-1:0] ctl_r;
  logic [OP_W-1:0]  opcode_r;
  logic [RA_W-1:0]  ra_r;
  logic [RA_W-1:0]  rb_r;
  logic             hazard_s;
  logic             src_match_s;

  // Load-use detection: a load in EX whose destination is read by the instruction in decode.
  always_comb begin
    src_match_s = 1'b0;
    if ((use_ra_i && (ra_i == ra_r)) || (use_rb_i && (rb_i == ra_r))) begin
      src_match_s = 1'b1;
    end else begin
      src_match_s = 1'b0;
    end
    hazard_s = valid_r & ctl_r[MEMREAD_BIT] & valid_i & src_match_s;
  end

  // Pipeline register: flush > stall > hazard bubble > load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r  <= 1'b0;
      ctl_r    <= {CTL_W{1'b0}};
      opcode_r <= NOP_OP;
      ra_r     <= {RA_W{1'b0}};
      rb_r     <= {RA_W{1'b0}};
    end else if (flush_i || (!stall_i && hazard_s)) begin
      valid_r  <= 1'b0;
      ctl_r    <= {CTL_W{1'b0}};
      opcode_r <= NOP_OP;
      ra_r     <= {RA_W{1'b0}};
      rb_r     <= {RA_W{1'b0}};
    end else if (stall_i) begin
      valid_r  <= valid_r;
      ctl_r    <= ctl_r;
      opcode_r <= opcode_r;
      ra_r     <= ra_r;
      rb_r     <= rb_r;
    end else begin
      valid_r  <= valid_i;
      // Invalid slots must never carry MemRead into EX.
      ctl_r    <= valid_i ? ctl_i : {CTL_W{1'b0}};
      opcode_r <= opcode_i;
      ra_r     <= ra_i;
      rb_r     <= rb_i;
    end
  end

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [15:0] stall_cnt_r;
  logic [15:0] bubble_cnt_r;

  // Saturating performance counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r  <= 16'h0000;
      bubble_cnt_r <= 16'h0000;
    end else begin
      if (!flush_i && stall_i && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'h0001;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (!flush_i && !stall_i && hazard_s && (bubble_cnt_r != 16'hFFFF)) begin
        bubble_cnt_r <= bubble_cnt_r + 16'h0001;
      end else begin
        bubble_cnt_r <= bubble_cnt_r;
      end
    end
  end

  assign stall_cnt_o  = stall_cnt_r;
  assign bubble_cnt_o = bubble_cnt_r;
`else
  assign stall_cnt_o  = 16'h0000;
  assign bubble_cnt_o = 16'h0000;
`endif

  assign valid_o  = valid_r;
  assign ctl_o    = ctl_r;
  assign opcode_o = opcode_r;
  assign ra_o     = ra_r;
  assign rb_o     = rb_r;
  assign hazard_o = hazard_s;

endmodule

// File: tb/tb_pipe_stage_ctl_reg.sv
// Table-driven bench for pipe_stage_ctl_reg: chained directed vectors plus async-reset and saturation sequences.
module tb_pipe_stage_ctl_reg;

  logic       clk;
  logic       rst_n;
  logic       stall_i, flush_i, valid_i, use_ra_i, use_rb_i;
  logic [4:0] ctl_i;
  logic [3:0] opcode_i;
  logic [2:0] ra_i, rb_i;
  logic       valid_o, hazard_o;
  logic [4:0] ctl_o;
  logic [3:0] opcode_o;
  logic [2:0] ra_o, rb_o;
  logic [15:0] stall_cnt_o, bubble_cnt_o;

  int n_vec;
  int n_bad;

  pipe_stage_ctl_reg dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .ctl_i(ctl_i), .opcode_i(opcode_i), .ra_i(ra_i), .rb_i(rb_i),
    .use_ra_i(use_ra_i), .use_rb_i(use_rb_i), .valid_o(valid_o), .ctl_o(ctl_o),
    .opcode_o(opcode_o), .ra_o(ra_o), .rb_o(rb_o), .hazard_o(hazard_o),
    .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       stall, flush, valid, use_ra, use_rb;
    logic [4:0] ctl;
    logic [3:0] op;
    logic [2:0] ra, rb;
    logic       hz;
    logic       ev;
    logic [4:0] ectl;
    logic [3:0] eop;
    logic [2:0] era, erb;
    logic [15:0] esc, ebc;
  } vec_t;

  vec_t vec[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic v, input logic [4:0] c, input logic [3:0] o,
                          input logic [2:0] a, input logic [2:0] b, input logic [15:0] sc, input logic [15:0] bc);
    logic [15:0] esc, ebc;
`ifdef PIPE_STAGE_PERF_CNT_EN
    esc = sc; ebc = bc;
`else
    esc = 16'h0000; ebc = 16'h0000;
`endif
    chk({tag, " valid_o"}, {15'h0, valid_o}, {15'h0, v});
    chk({tag, " ctl_o"}, {11'h0, ctl_o}, {11'h0, c});
    chk({tag, " opcode_o"}, {12'h0, opcode_o}, {12'h0, o});
    chk({tag, " ra_o"}, {13'h0, ra_o}, {13'h0, a});
    chk({tag, " rb_o"}, {13'h0, rb_o}, {13'h0, b});
    chk({tag, " stall_cnt_o"}, stall_cnt_o, esc);
    chk({tag, " bubble_cnt_o"}, bubble_cnt_o, ebc);
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; use_ra_i = 1'b0; use_rb_i = 1'b0;
    ctl_i = 5'h00; opcode_i = 4'h0; ra_i = 3'd0; rb_i = 3'd0;

    //          st    fl    va    ura   urb   ctl       op     ra    rb    hz    ev    ectl      eop    era   erb   esc       ebc
    vec.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0,5'b00101,4'h3,3'd2,3'd6,1'b0,1'b1,5'b00101,4'h3,3'd2,3'd6,16'd0,16'd0}); // plain load
    vec.push_back('{1'b0,1'b0,1'b0,1'b0,1'b0,5'h1F,   4'h7,3'd1,3'd1,1'b0,1'b0,5'h00,   4'h7,3'd1,3'd1,16'd0,16'd0}); // invalid -> ctl 0
    vec.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0,5'b10000,4'h8,3'd3,3'd0,1'b0,1'b1,5'b10000,4'h8,3'd3,3'd0,16'd0,16'd0}); // load into EX
    vec.push_back('{1'b0,1'b0,1'b1,1'b0,1'b1,5'b00001,4'h2,3'd5,3'd3,1'b1,1'b0,5'h00,   4'h0,3'd0,3'd0,16'd0,16'd1}); // rb hazard -> bubble
    vec.push_back('{1'b0,1'b0,1'b1,1'b0,1'b1,5'b00001,4'h2,3'd5,3'd3,1'b0,1'b1,5'b00001,4'h2,3'd5,3'd3,16'd0,16'd1}); // held instr loads
    vec.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0,5'b10010,4'h9,3'd3,3'd1,1'b0,1'b1,5'b10010,4'h9,3'd3,3'd1,16'd0,16'd1}); // load into EX
    vec.push_back('{1'b0,1'b0,1'b1,1'b1,1'b1,5'b00100,4'h5,3'd6,3'd4,1'b0,1'b1,5'b00100,4'h5,3'd6,3'd4,16'd0,16'd1}); // rb=4: no hazard
    vec.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0,5'b10000,4'h8,3'd0,3'd7,1'b0,1'b1,5'b10000,4'h8,3'd0,3'd7,16'd0,16'd1}); // load to r0
    vec.push_back('{1'b1,1'b0,1'b1,1'b1,1'b0,5'b00011,4'hA,3'd0,3'd2,1'b1,1'b1,5'b10000,4'h8,3'd0,3'd7,16'd1,16'd1}); // stall w/ hazard: hold
    vec.push_back('{1'b1,1'b0,1'b1,1'b0,1'b0,5'h1F,   4'hF,3'd7,3'd7,1'b0,1'b1,5'b10000,4'h8,3'd0,3'd7,16'd2,16'd1}); // stall: hold
    vec.push_back('{1'b1,1'b0,1'b1,1'b1,1'b0,5'b00011,4'hA,3'd0,3'd2,1'b1,1'b1,5'b10000,4'h8,3'd0,3'd7,16'd3,16'd1}); // stall: hold
    vec.push_back('{1'b0,1'b0,1'b1,1'b1,1'b0,5'b00011,4'hA,3'd0,3'd2,1'b1,1'b0,5'h00,   4'h0,3'd0,3'd0,16'd3,16'd2}); // r0 hazard bubble
    vec.push_back('{1'b0,1'b0,1'b1,1'b1,1'b0,5'b00011,4'hA,3'd0,3'd2,1'b0,1'b1,5'b00011,4'hA,3'd0,3'd2,16'd3,16'd2}); // held loads
    vec.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0,5'b11000,4'h8,3'd5,3'd1,1'b0,1'b1,5'b11000,4'h8,3'd5,3'd1,16'd3,16'd2}); // load into EX
    vec.push_back('{1'b0,1'b1,1'b1,1'b0,1'b1,5'b00110,4'h6,3'd2,3'd5,1'b1,1'b0,5'h00,   4'h0,3'd0,3'd0,16'd3,16'd2}); // flush beats hazard
    vec.push_back('{1'b0,1'b0,1'b1,1'b0,1'b1,5'b00110,4'h6,3'd2,3'd5,1'b0,1'b1,5'b00110,4'h6,3'd2,3'd5,16'd3,16'd2}); // load
    vec.push_back('{1'b1,1'b1,1'b1,1'b0,1'b0,5'h1F,   4'hF,3'd7,3'd7,1'b0,1'b0,5'h00,   4'h0,3'd0,3'd0,16'd3,16'd2}); // flush beats stall
    vec.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0,5'b10000,4'h8,3'd4,3'd0,1'b0,1'b1,5'b10000,4'h8,3'd4,3'd0,16'd3,16'd2}); // load into EX
    vec.push_back('{1'b0,1'b0,1'b1,1'b1,1'b0,5'b00001,4'h1,3'd4,3'd3,1'b1,1'b0,5'h00,   4'h0,3'd0,3'd0,16'd3,16'd3}); // ra hazard bubble
    vec.push_back('{1'b0,1'b0,1'b1,1'b1,1'b0,5'b00001,4'h1,3'd4,3'd3,1'b0,1'b1,5'b00001,4'h1,3'd4,3'd3,16'd3,16'd3}); // held loads
    vec.push_back('{1'b1,1'b0,1'b1,1'b0,1'b0,5'h0F,   4'hE,3'd1,3'd1,1'b0,1'b1,5'b00001,4'h1,3'd4,3'd3,16'd4,16'd3}); // stall: hold
    vec.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0,5'b10000,4'h8,3'd2,3'd0,1'b0,1'b1,5'b10000,4'h8,3'd2,3'd0,16'd4,16'd3}); // load into EX
    vec.push_back('{1'b0,1'b0,1'b0,1'b1,1'b0,5'h1F,   4'h3,3'd2,3'd0,1'b0,1'b0,5'h00,   4'h3,3'd2,3'd0,16'd4,16'd3}); // invalid decode: no hazard

    // The counters above are cumulative; the bubble count is 3 because the r0, rb and ra hazards each bubbled.
    #2;
    chk_outs("reset", 1'b0, 5'h00, 4'h0, 3'd0, 3'd0, 16'd0, 16'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vec[i]) begin
      stall_i = vec[i].stall; flush_i = vec[i].flush; valid_i = vec[i].valid;
      use_ra_i = vec[i].use_ra; use_rb_i = vec[i].use_rb; ctl_i = vec[i].ctl;
      opcode_i = vec[i].op; ra_i = vec[i].ra; rb_i = vec[i].rb;
      #2;
      chk($sformatf("v%0d hazard_o", i), {15'h0, hazard_o}, {15'h0, vec[i].hz});
      @(posedge clk); #1;
      chk_outs($sformatf("v%0d", i), vec[i].ev, vec[i].ectl, vec[i].eop, vec[i].era, vec[i].erb,
               vec[i].esc, vec[i].ebc);
    end

    // Asynchronous reset between edges, while a hazard is pending.
    stall_i = 1'b0; flush_i = 1'b0; use_ra_i = 1'b0; use_rb_i = 1'b0;
    valid_i = 1'b1; ctl_i = 5'h1F; opcode_i = 4'h9; ra_i = 3'd3; rb_i = 3'd5;
    @(posedge clk); #1;
    chk_outs("preload", 1'b1, 5'h1F, 4'h9, 3'd3, 3'd5, 16'd4, 16'd3);
    use_ra_i = 1'b1; #1;
    chk("preload hazard_o", {15'h0, hazard_o}, 16'h0001);
    #1 rst_n = 1'b0;
    #1;
    chk_outs("async reset", 1'b0, 5'h00, 4'h0, 3'd0, 3'd0, 16'd0, 16'd0);
    chk("async reset hazard_o", {15'h0, hazard_o}, 16'h0000);
    @(negedge clk) rst_n = 1'b1;
    valid_i = 1'b0; use_ra_i = 1'b0;

`ifdef PIPE_STAGE_PERF_CNT_EN
    // Long stall drives the stall counter into saturation.
    stall_i = 1'b1;
    repeat (65537) @(posedge clk);
    #1;
    chk("sat stall_cnt_o", stall_cnt_o, 16'hFFFF);
    @(posedge clk); #1;
    chk("sat hold stall_cnt_o", stall_cnt_o, 16'hFFFF);
    chk("sat bubble_cnt_o", bubble_cnt_o, 16'h0000);
    stall_i = 1'b0;
`else
    stall_i = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("off stall_cnt_o", stall_cnt_o, 16'h0000);
    stall_i = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_ctl_reg.md
Name: pipe_stage_ctl_reg

Overview:
Parametrised ID->EX control pipeline register, successor to the fixed-width phase-3 control latch.
- Carries control bits, opcode and two register addresses plus a valid bit.
- Adds stall (hold), flush (bubble) and built-in load-use hazard detection that inserts a bubble and requests an upstream stall.
- Sits between decode and execute in the simple pipeline.

Parameters:
CTL_W, 5, number of control bits carried (ALUSrc1, ALUSrc2, ALUorshifter, AS_BC, MemRead in the default packing)
OP_W, 4, opcode width
RA_W, 3, register address width
MEMREAD_BIT, 4, index within ctl_i of the MemRead bit
NOP_OP, 4'b0000, opcode loaded on flush or bubble; width OP_W

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; asynchronous, active-low
stall_i  in  1  downstream stall; hold all contents
flush_i  in  1  squash; load bubble
valid_i  in  1  decode slot holds a real instruction
ctl_i  in  CTL_W  decoded control bits
opcode_i  in  OP_W  decoded opcode
ra_i  in  RA_W  Ra field; for loads this is the destination
rb_i  in  RA_W  Rb field
use_ra_i  in  1  instruction in decode reads Ra
use_rb_i  in  1  instruction in decode reads Rb
valid_o  out  1  execute slot valid
ctl_o  out  CTL_W  registered control
opcode_o  out  OP_W  registered opcode
ra_o  out  RA_W  registered Ra
rb_o  out  RA_W  registered Rb
hazard_o  out  1  combinational load-use stall request to PC and IF/ID
stall_cnt_o  out  16  stall-cycle counter (see Optional Feature)
bubble_cnt_o  out  16  bubble counter (see Optional Feature)

Behaviour:
- Reset:
  - rst_n low clears immediately, independent of clk: valid_o=0, ctl_o=0, opcode_o=NOP_OP, ra_o=0, rb_o=0, counters=0.
  - Reset asserted mid-stall or mid-hazard aborts that operation.
  - First load after rst_n deasserts occurs on the next rising edge.
- hazard_o (combinational):
  - hazard_o = valid_o & ctl_o[MEMREAD_BIT] & valid_i & ((use_ra_i & ra_i==ra_o) | (use_rb_i & rb_i==ra_o)).
  - Register address 0 is not special.
- Per rising edge, priority flush_i > stall_i > hazard_o > load:
  - flush_i=1: load bubble. valid_o=0, ctl_o=0, opcode_o=NOP_OP, ra_o=rb_o=0. Overrides stall_i.
  - stall_i=1 (no flush): all registers hold. hazard_o may still be asserted; no bubble is inserted.
  - hazard_o=1 (no flush, no stall): load bubble as above. Upstream holds the decode slot because of hazard_o. On the next cycle ctl_o[MEMREAD_BIT]=0, so hazard_o drops and the held instruction loads. Exactly one bubble per load-use pair.
  - Otherwise: load. valid_o=valid_i; other fields take their inputs. When valid_i=0, ctl_o is forced to 0 so invalid slots never assert MemRead.
- Latency: 1 cycle input->output on load.
- No state machine beyond the valid bit. Hold, bubble and load are mutually exclusive per cycle.

Optional Feature:
Macro PIPE_STAGE_PERF_CNT_EN.
- Defined:
  - stall_cnt_o increments on each edge with stall_i=1 and flush_i=0.
  - bubble_cnt_o increments on each edge with hazard_o=1, stall_i=0 and flush_i=0.
  - Both are 16-bit, saturate at 16'hFFFF (no wrap) and clear on reset only.
- Not defined: counter flops are absent and both ports are driven constant 0. All other behaviour is identical.

Test Plan:
- Async reset: load valid_i=1, ctl_i=5'h1F, opcode_i=4'h9, ra_i=3, rb_i=5, then drop rst_n between edges -> all outputs 0 and opcode_o=NOP_OP immediately, with no clock edge.
- Plain load: valid_i=1, ctl_i=5'b00101, opcode_i=4'h3, ra_i=2, rb_i=6 -> next edge valid_o=1 and outputs match; valid_i=0 with ctl_i=5'h1F -> ctl_o=0, valid_o=0.
- Load-use: EX holds a load (ctl_o[4]=1, ra_o=3); decode has use_rb_i=1, rb_i=3 -> hazard_o=1 in the same cycle; next edge gives a bubble (valid_o=0, opcode_o=NOP_OP); hazard_o then 0 and the held instruction loads one edge later. Repeat with rb_i=4 -> hazard_o=0, no bubble.
- Stall: stall_i=1 for 3 edges with changing inputs -> outputs frozen. Assert flush_i together with stall_i -> bubble loads.
- Flush priority: flush_i=1 with hazard_o=1 and valid_i=1 -> bubble, and bubble_cnt_o does not increment.
- Perf counters (macro defined): 4 stall edges and 2 hazard bubbles -> stall_cnt_o=4, bubble_cnt_o=2. Preload near saturation via long stall (65537 edges) -> stall_cnt_o=16'hFFFF. Macro undefined -> both read 0 throughout.
